// File: rtl/remote_service_latency_tracker.sv
// Responder-side service latency tracker: timestamps requests, matches
// in-order returns, keeps per-type count/sum/max stats and a trace strobe.
// Ports: clk_i/reset_i; req_v_i/req_yumi_i/req_type_i push side;
// ret_v_i/ret_ready_i pop side; global_ctr_i timestamp; clear_i stats clear.
// Outputs: count_o, lat_sum_o, lat_max_o (slot i = type i), outstanding_o,
// overflow_o, underflow_o sticky flags, trace_v_o/type/latency strobe.
module remote_service_latency_tracker #(
  parameter int fifo_els_p  = 16,
  parameter int ctr_width_p = 32,
  parameter int lat_width_p = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          req_v_i,
  input  logic                          req_yumi_i,
  input  logic [1:0]                    req_type_i,
  input  logic                          ret_v_i,
  input  logic                          ret_ready_i,
  input  logic [31:0]                   global_ctr_i,
  input  logic                          clear_i,
  output logic [3*ctr_width_p-1:0]      count_o,
  output logic [3*ctr_width_p-1:0]      lat_sum_o,
  output logic [3*lat_width_p-1:0]      lat_max_o,
  output logic [$clog2(fifo_els_p):0]   outstanding_o,
  output logic                          overflow_o,
  output logic                          underflow_o,
  output logic                          trace_v_o,
  output logic [1:0]                    trace_type_o,
  output logic [lat_width_p-1:0]        trace_latency_o
);
  localparam int AW = $clog2(fifo_els_p);

  // Entry layout: {type[1:0], start_ts[31:0]}
  logic [33:0]              r_mem [fifo_els_p];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [AW:0]              r_occ;
  logic                     r_ovf;
  logic                     r_unf;
  logic [ctr_width_p-1:0]   r_cnt [3];
  logic [ctr_width_p-1:0]   r_sum [3];
  logic [lat_width_p-1:0]   r_max [3];
  logic                     r_trace_v;
  logic [1:0]               r_trace_type;
  logic [lat_width_p-1:0]   r_trace_lat;

  logic                     w_push_req;
  logic                     w_pop_req;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic [33:0]              w_head;
  logic [1:0]               w_head_type;
  logic [31:0]              w_diff;
  logic                     w_sat;
  logic [lat_width_p-1:0]   w_lat;
  logic [ctr_width_p:0]     w_sum_ext [3];
  logic [ctr_width_p-1:0]   w_sum_nxt [3];

  assign w_push_req  = req_v_i & req_yumi_i & (req_type_i != 2'd3);
  assign w_pop_req   = ret_v_i & ret_ready_i;
  assign w_empty     = (r_occ == '0);
  assign w_full      = (r_occ == (AW+1)'(fifo_els_p));
  // A same-cycle push never feeds the pop: pop only sees stored entries.
  assign w_pop       = w_pop_req & ~w_empty;
  // When full, a concurrent pop frees the slot the push lands in.
  assign w_push      = w_push_req & (~w_full | w_pop);

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_type = w_head[33:32];
  // Modulo-2^32 difference handles counter wrap.
  assign w_diff      = global_ctr_i - w_head[31:0];
  assign w_sat       = (w_diff >> lat_width_p) != '0;
  assign w_lat       = w_sat ? '1 : w_diff[lat_width_p-1:0];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_sum_ext[i] = {1'b0, r_sum[i]} + (ctr_width_p+1)'(w_lat);
      w_sum_nxt[i] = w_sum_ext[i][ctr_width_p] ? '1
                                               : w_sum_ext[i][ctr_width_p-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {req_type_i, global_ctr_i};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (AW+1)'(1);
        2'b01:   r_occ <= r_occ - (AW+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (clear_i) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_pop_req & w_empty)         r_unf <= 1'b1;
      if (w_push_req & w_full & ~w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
        r_sum[i] <= '0;
        r_max[i] <= '0;
      end
    end else if (clear_i) begin
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
        r_sum[i] <= '0;
        r_max[i] <= '0;
      end
    end else if (w_pop) begin
      for (int i = 0; i < 3; i++) begin
        if (w_head_type == 2'(i)) begin
          if (~&r_cnt[i]) r_cnt[i] <= r_cnt[i] + ctr_width_p'(1);
          r_sum[i] <= w_sum_nxt[i];
          if (w_lat > r_max[i]) r_max[i] <= w_lat;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_trace_v    <= 1'b0;
      r_trace_type <= '0;
      r_trace_lat  <= '0;
    end else if (clear_i) begin
      r_trace_v    <= 1'b0;
    end else begin
      r_trace_v <= w_pop;
      if (w_pop) begin
        r_trace_type <= w_head_type;
        r_trace_lat  <= w_lat;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_pack
    assign count_o[g*ctr_width_p +: ctr_width_p]   = r_cnt[g];
    assign lat_sum_o[g*ctr_width_p +: ctr_width_p] = r_sum[g];
    assign lat_max_o[g*lat_width_p +: lat_width_p] = r_max[g];
  end

  assign outstanding_o   = r_occ;
  assign overflow_o      = r_ovf;
  assign underflow_o     = r_unf;
  assign trace_v_o       = r_trace_v;
  assign trace_type_o    = r_trace_type;
  assign trace_latency_o = r_trace_lat;

endmodule

// File: tb/tb_remote_service_latency_tracker.sv
// Bench for remote_service_latency_tracker: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_remote_service_latency_tracker;
  localparam int N  = 16;
  localparam int CW = 32;
  localparam int LW = 16;

  logic            clk;
  logic            rst;
  logic            req_v, req_yumi, ret_v, ret_ready, clr;
  logic [1:0]      req_type;
  logic [31:0]     gctr;
  logic [3*CW-1:0] count_o, sum_o;
  logic [3*LW-1:0] max_o;
  logic [4:0]      outst_o;
  logic            ovf_o, unf_o, tv_o;
  logic [1:0]      tt_o;
  logic [LW-1:0]   tl_o;

  remote_service_latency_tracker #(
    .fifo_els_p(N), .ctr_width_p(CW), .lat_width_p(LW)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .req_v_i(req_v), .req_yumi_i(req_yumi), .req_type_i(req_type),
    .ret_v_i(ret_v), .ret_ready_i(ret_ready),
    .global_ctr_i(gctr), .clear_i(clr),
    .count_o(count_o), .lat_sum_o(sum_o), .lat_max_o(max_o),
    .outstanding_o(outst_o), .overflow_o(ovf_o), .underflow_o(unf_o),
    .trace_v_o(tv_o), .trace_type_o(tt_o), .trace_latency_o(tl_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] ts;
  } ent_t;

  ent_t    q[$];
  longint  m_cnt [3];
  longint  m_sum [3];
  longint  m_max [3];
  bit      m_ovf, m_unf, m_tv;
  int      m_tt;
  longint  m_tl;
  int      n_chk = 0;
  int      n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_sum[i] = 0; m_max[i] = 0;
    end
    m_ovf = 0; m_unf = 0; m_tv = 0; m_tt = 0; m_tl = 0;
  endtask

  task automatic model_step(input bit push, input bit pop,
                            input logic [1:0] t, input logic [31:0] c,
                            input bit cl);
    logic [31:0] d;
    longint      lat;
    ent_t        e;
    m_tv = 0;
    if (pop) begin
      if (q.size() == 0) m_unf = 1;
      else begin
        e   = q.pop_front();
        d   = c - e.ts;
        lat = (d > 32'hFFFF) ? 65535 : longint'(d);
        if (!cl) begin
          m_cnt[e.t] = (m_cnt[e.t] + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF
                                                         : m_cnt[e.t] + 1;
          m_sum[e.t] = (m_sum[e.t] + lat > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF
                                                           : m_sum[e.t] + lat;
          if (lat > m_max[e.t]) m_max[e.t] = lat;
          m_tv = 1; m_tt = e.t; m_tl = lat;
        end
      end
    end
    if (push) begin
      if (q.size() == N) m_ovf = 1;
      else begin
        e.t = t; e.ts = c;
        q.push_back(e);
      end
    end
    if (cl) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 0; m_sum[i] = 0; m_max[i] = 0;
      end
      m_ovf = 0; m_unf = 0; m_tv = 0;
    end
  endtask

  task automatic cmp_all(input string ph);
    logic [3*CW-1:0] ec, es;
    logic [3*LW-1:0] em;
    for (int i = 0; i < 3; i++) begin
      ec[i*CW +: CW] = m_cnt[i][CW-1:0];
      es[i*CW +: CW] = m_sum[i][CW-1:0];
      em[i*LW +: LW] = m_max[i][LW-1:0];
    end
    check({ph, ".outst"}, outst_o, q.size());
    check({ph, ".ovf"}, ovf_o, m_ovf);
    check({ph, ".unf"}, unf_o, m_unf);
    check({ph, ".tv"}, tv_o, m_tv);
    check({ph, ".ttype"}, tt_o, m_tt);
    check({ph, ".tlat"}, tl_o, m_tl);
    check({ph, ".count"}, count_o, ec);
    check({ph, ".sum"}, sum_o, es);
    check({ph, ".max"}, max_o, em);
  endtask

  task automatic step(input string ph, input logic rv, input logic ry,
                      input logic [1:0] rt, input logic pv, input logic pr,
                      input logic [31:0] c, input logic cl);
    req_v = rv; req_yumi = ry; req_type = rt;
    ret_v = pv; ret_ready = pr; gctr = c; clr = cl;
    @(posedge clk);
    model_step(rv & ry & (rt != 2'd3), pv & pr, rt, c, cl);
    #1;
    cmp_all(ph);
  endtask

  task automatic push(input string ph, input logic [1:0] t,
                      input logic [31:0] c);
    step(ph, 1, 1, t, 0, 0, c, 0);
  endtask

  task automatic pop(input string ph, input logic [31:0] c);
    step(ph, 0, 0, 0, 1, 1, c, 0);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    cmp_all("async_rst");
    req_v = 0; req_yumi = 0; ret_v = 0; ret_ready = 0; clr = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    cmp_all("post_rst");
  endtask

  initial begin
    logic [31:0] c;
    int          pct_push, pct_pop;
    rst = 1'b1;
    req_v = 0; req_yumi = 0; req_type = 0;
    ret_v = 0; ret_ready = 0; gctr = 0; clr = 0;
    model_reset();
    #1 cmp_all("reset");
    #16 rst = 1'b0;
    @(posedge clk);
    #1;

    push("t1", 0, 100);
    pop("t1", 137);
    check("t1.lat37", tl_o, 37);
    check("t1.max37", max_o[LW-1:0], 37);

    push("t2", 1, 10);
    push("t2", 2, 11);
    push("t2", 0, 12);
    check("t2.outst3", outst_o, 3);
    pop("t2", 20);
    check("t2.lat_st", tl_o, 10);
    pop("t2", 25);
    check("t2.lat_amo", tl_o, 14);
    pop("t2", 40);
    check("t2.lat_ld", tl_o, 28);
    check("t2.outst0", outst_o, 0);

    push("t3", 1, 32'hFFFF_FFF0);
    pop("t3", 32'h10);
    check("t3.wrap", tl_o, 16'h20);
    push("t3", 2, 0);
    pop("t3", 70000);
    check("t3.sat", tl_o, 16'hFFFF);

    for (int i = 0; i < N; i++) push("t4", 2'(i % 3), 1000 + i);
    push("t4", 1, 1050);
    check("t4.ovf", ovf_o, 1);
    check("t4.full", outst_o, N);
    step("t4", 1, 1, 0, 1, 1, 1100, 0);
    check("t4.pp_lat", tl_o, 100);
    check("t4.pp_full", outst_o, N);
    for (int i = 0; i < N; i++) pop("t4", 1200 + i);

    pop("t5", 1300);
    check("t5.unf", unf_o, 1);
    check("t5.notrace", tv_o, 0);
    step("t5", 1, 1, 2, 1, 1, 500, 0);
    check("t5.outst1", outst_o, 1);
    pop("t5", 510);
    check("t5.lat", tl_o, 10);

    push("t6", 0, 600);
    push("t6", 1, 605);
    step("t6", 0, 0, 0, 0, 0, 610, 1);
    check("t6.clr_cnt", count_o, 0);
    check("t6.clr_flags", {ovf_o, unf_o}, 0);
    pop("t6", 620);
    check("t6.lat_a", tl_o, 20);
    pop("t6", 630);
    check("t6.lat_b", tl_o, 25);

    push("t7", 0, 700);
    push("t7", 2, 701);
    mid_reset();
    check("t7.outst", outst_o, 0);

    c = 32'h1234;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) mid_reset();
      pct_push = ((i / 250) % 2 == 0) ? 75 : 30;
      pct_pop  = 100 - pct_push;
      c = c + $urandom_range(0, 3);
      if ($urandom_range(0, 63) == 0) c = c + $urandom;
      step("rnd",
           $urandom_range(0, 99) < pct_push,
           $urandom_range(0, 7) != 0,
           2'($urandom_range(0, 3)),
           $urandom_range(0, 99) < pct_pop,
           $urandom_range(0, 7) != 0,
           c,
           $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/remote_service_latency_tracker.md
Name: remote_service_latency_tracker

Overview:
- Responder-side counterpart of the tile-side remote load tracer. Sits at the receive endpoint of a manycore responder (vcache or tile DMEM endpoint).
- Timestamps each accepted incoming request that will produce a return packet, then matches it to the outgoing return packet. Responders return in order, so matching uses an in-order FIFO.
- Accumulates per-type service-latency statistics (count, sum, max) and emits a one-cycle trace strobe per completed transaction.
- Synthesizable; usable in both simulation and FPGA profiling builds.

Parameters:
- fifo_els_p, 16, max outstanding requests tracked; must be a power of 2, ≥2.
- ctr_width_p, 32, width of the count and sum statistics counters.
- lat_width_p, 16, width of latency values; larger values saturate.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  reset, asynchronous, active-high.
- req_v_i  input  1  incoming request valid.
- req_yumi_i  input  1  responder accepts the request this cycle.
- req_type_i  input  2  0=load, 1=store, 2=amo, 3=no-response (ignored).
- ret_v_i  input  1  outgoing return packet valid.
- ret_ready_i  input  1  network accepts the return packet.
- global_ctr_i  input  32  free-running global cycle counter.
- clear_i  input  1  synchronous clear of statistics and sticky flags.
- count_o  output  3*ctr_width_p  per-type completed count; slot i holds type i.
- lat_sum_o  output  3*ctr_width_p  per-type latency sum.
- lat_max_o  output  3*lat_width_p  per-type maximum latency.
- outstanding_o  output  clog2(fifo_els_p)+1  current FIFO occupancy.
- overflow_o  output  1  sticky: a push was dropped because the FIFO was full.
- underflow_o  output  1  sticky: a return was accepted while the FIFO was empty.
- trace_v_o  output  1  one-cycle strobe per completed transaction.
- trace_type_o  output  2  type of the traced transaction.
- trace_latency_o  output  lat_width_p  latency of the traced transaction.

Behaviour:
- Push condition: req_v_i & req_yumi_i & (req_type_i != 3). Pushes entry {type, global_ctr_i}.
- Pop condition: ret_v_i & ret_ready_i. Pops the head entry.
- Latency = (global_ctr_i − entry start), computed modulo 2^32 so counter wrap-around is handled. If the result exceeds 2^lat_width_p − 1, it saturates to all ones.
- Pop with occupancy 0:
  - sets underflow_o;
  - no stats update, no trace;
  - a simultaneous push still occurs.
- A push in the same cycle cannot satisfy a pop in that cycle.
- Push with occupancy fifo_els_p and no simultaneous pop:
  - the entry is dropped and overflow_o is set;
  - occupancy is unchanged.
- Push and pop together when full: both take effect; occupancy stays full.
- Stats update is registered; it becomes visible the cycle after the pop. For the popped type t:
  - count[t] += 1, saturating at all ones;
  - sum[t] += latency, saturating at all ones;
  - max[t] = max(max[t], latency).
- Trace outputs:
  - trace_v_o, trace_type_o and trace_latency_o are registered, valid the cycle after the pop;
  - trace_v_o is 1 for exactly one cycle per successful pop;
  - trace_type_o and trace_latency_o hold their last value when trace_v_o = 0.
- clear_i, applied at a clock edge:
  - zeroes all stats and both sticky flags, and deasserts trace_v_o;
  - FIFO contents and occupancy are preserved, so in-flight transactions are still matched;
  - a pop in the same cycle as clear_i is discarded from stats; clear wins.
- Reset (asynchronous assert, mid-operation included): all outputs, the FIFO pointers, occupancy, stats and flags go to 0 immediately. Entries in flight at reset are forgotten.
- outstanding_o is the registered occupancy; it reflects a push or pop the cycle after it occurs.

Test Plan:
- After reset, push load at ctr=100, pop at ctr=137 → next cycle trace_v_o=1, type=0, latency=37; count[0]=1, sum[0]=37, max[0]=37.
- Push store@10, amo@11, load@12; pop at ctr 20, 25, 40 → traces (1,10), (2,14), (0,28), in order; outstanding_o goes 3→0.
- Push at ctr=0xFFFFFFF0, pop at ctr=0x00000010 → latency=0x20. Separately, push at 0, pop at 70000 with lat_width_p=16 → latency=0xFFFF.
- Fill 16 entries, push a 17th alone → overflow_o=1, outstanding_o=16. Then push and pop in the same cycle → occupancy 16; the popped latency matches the oldest entry.
- Pop with FIFO empty (with and without a simultaneous push) → underflow_o=1, no trace, stats unchanged; with the push, outstanding_o=1 next cycle.
- clear_i with 2 entries outstanding → stats and flags become 0; subsequent pops produce correct latencies. Asserting reset_i mid-stream → all outputs 0 without waiting for a clock edge.
